// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - shared codes, state constants and helpers for the GPU command port
package gpu_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_SPECIAL = 2'b00,
        CMD_READ    = 2'b01,
        CMD_WRITE   = 2'b10,
        CMD_RESET   = 2'b11
    } cmdType_t;

    typedef enum logic [2:0] {
        MEM_ALL     = 3'd0,
        MEM_HEADERS = 3'd1,
        MEM_RAM     = 3'd2,
        MEM_PALETTE = 3'd3,
        MEM_FLASH   = 3'd4
    } memTarget_t;

    localparam logic [13:0] SPECIAL_NOP          = 14'h0000;
    localparam logic [13:0] SPECIAL_UPDATE_FRAME = 14'h0001;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_RDY = 3'd1;
    localparam logic [2:0] ST_SETUP    = 3'd2;
    localparam logic [2:0] ST_CLK_HIGH = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic isReadCmd(input logic [15:0] cmd);
        return cmd[15:14] == CMD_READ;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for the GPU RDY/#BSY pin
module sync_2ff (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic meta;

    // Resets to 0 so the GPU is treated as busy until the pin has been seen high.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpu_command_transmitter.sv
// rtl/gpu_command_transmitter.sv - host-side initiator driving the GPU parallel command port
module gpu_command_transmitter
    import gpu_cmd_pkg::*;
#(
    parameter int SETUP_CYCLES    = 2,
    parameter int CLK_HIGH_CYCLES = 2,
    parameter int HOLD_CYCLES     = 2,
    parameter int READ_LAT_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        gpuClk,
    input  logic        rst,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [15:0] cmdIn,
    input  logic [15:0] wrDataIn,
    output logic [15:0] rdData,
    output logic        rdValid,
    output logic        timeoutErr,
    output logic        busy,
    input  logic        readyBusy,
    output logic        chipSelect,
    output logic        outputEnable,
    output logic        commandClk,
    output logic [15:0] busCommand,
    inout  wire  [15:0] dataInOut
);

    localparam int MAX_PHASE = maxInt(maxInt(SETUP_CYCLES, CLK_HIGH_CYCLES),
                                      maxInt(HOLD_CYCLES, READ_LAT_CYCLES));
    localparam int PW = $clog2(MAX_PHASE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    state;
    logic [15:0]   cmdLatch;
    logic [15:0]   dataLatch;
    logic [PW-1:0] phaseCnt;
    logic [PW-1:0] phaseNext;
    logic          phaseLast;
    logic [TW-1:0] waitCnt;
    logic          dataOe;
    logic          rdySync;
    logic          isRd;

    sync_2ff u_rdySync (
        .clk  (gpuClk),
        .rstN (rst),
        .d    (readyBusy),
        .q    (rdySync)
    );

    assign isRd      = isReadCmd(cmdLatch);
    assign cmdReady  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign dataInOut = dataOe ? dataLatch : 16'hzzzz;
    assign phaseNext = (phaseCnt == PW'(MAX_PHASE)) ? phaseCnt : phaseCnt + 1'b1;

    always_comb begin
        phaseLast = 1'b0;
        case (state)
            ST_SETUP:    phaseLast = (phaseCnt == PW'(SETUP_CYCLES - 1));
            ST_CLK_HIGH: phaseLast = (phaseCnt == PW'(CLK_HIGH_CYCLES - 1));
            ST_HOLD:     phaseLast = isRd ? (phaseCnt == PW'(READ_LAT_CYCLES - 1))
                                          : (phaseCnt == PW'(HOLD_CYCLES - 1));
            default:     phaseLast = 1'b0;
        endcase
    end

    always_ff @(posedge gpuClk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cmdLatch     <= '0;
            dataLatch    <= '0;
            phaseCnt     <= '0;
            waitCnt      <= '0;
            dataOe       <= 1'b0;
            chipSelect   <= 1'b1;
            outputEnable <= 1'b1;
            commandClk   <= 1'b0;
            busCommand   <= '0;
            rdData       <= '0;
            rdValid      <= 1'b0;
            timeoutErr   <= 1'b0;
        end else begin
            rdValid    <= 1'b0;
            timeoutErr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmdValid) begin
                        cmdLatch   <= cmdIn;
                        dataLatch  <= wrDataIn;
                        waitCnt    <= '0;
                        chipSelect <= 1'b0;
                        state      <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (rdySync) begin
                        busCommand   <= cmdLatch;
                        outputEnable <= ~isRd;
                        dataOe       <= ~isRd;
                        phaseCnt     <= '0;
                        state        <= ST_SETUP;
                    end else if (waitCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        // GPU never became ready: drop the command without touching the strobe.
                        timeoutErr <= 1'b1;
                        chipSelect <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (phaseLast) begin
                        commandClk <= 1'b1;
                        phaseCnt   <= '0;
                        state      <= ST_CLK_HIGH;
                    end else begin
                        phaseCnt <= phaseNext;
                    end
                end
                ST_CLK_HIGH: begin
                    if (phaseLast) begin
                        commandClk <= 1'b0;
                        phaseCnt   <= '0;
                        state      <= ST_HOLD;
                    end else begin
                        phaseCnt <= phaseNext;
                    end
                end
                ST_HOLD: begin
                    if (phaseLast) begin
                        // Sampling on the exit edge captures the bus as seen during the last HOLD cycle.
                        if (isRd) begin
                            rdData  <= dataInOut;
                            rdValid <= 1'b1;
                        end
                        chipSelect   <= 1'b1;
                        outputEnable <= 1'b1;
                        dataOe       <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        phaseCnt <= phaseNext;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
